// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// datapath mux selects and ALU function codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  // Internal per-state ALU request handed to mc_alu_decode.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;

  function automatic logic [1:0] imm_for_opcode(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// ALU function decode: fixed ADD/SUB requests or funct3/funct7-driven ops.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type: addi never subtracts.
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multi-cycle RV32I core, with branch resolution
// and the unified memory-port handshake.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       sign,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       taken;

  // NOTE: sequential state uses non-blocking assignment; the async reset
  // forces START, and every output decodes to 0 from START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_START;
    else        state_q <= state_d;
  end

  always_comb begin
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = sign;
      default: taken = 1'b0;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = imm_for_opcode(opcode);
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = imm_for_opcode(opcode);
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        // Target was parked in ALUOut during DECODE; ALU now compares rs1/rs2.
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        pc_write   = taken;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP:  halted = 1'b1;
      default: state_d = S_START;
    endcase
  end

  mc_alu_decode u_alu_decode (
    .alu_op      (alu_op),
    .op5         (opcode[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: random instructions and memory
// wait states checked per retired instruction against a reference model.
module tb_multicycle_controller;

  logic       clk, rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, zero, sign, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_control;
  logic       instr_done, halted;
  logic [18:0] outs;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .sign(sign), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .alu_control(alu_control), .instr_done(instr_done),
    .halted(halted)
  );

  assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, result_src, imm_src, alu_control,
                 instr_done, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5;
  localparam int NONE = 3;  // alu code never produced: rs1 never used

  // One record per instruction: counts/values seen over its whole lifetime.
  typedef struct {
    int lat; int alu; int pcw; int regw; int res;
    int memreq; int memw; int imm; int irw; int halt;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs;
  int   tests = 0, fails = 0;
  bit   mon_en = 0, first_fetch_chk = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic rec_t empty_rec();
    rec_t r;
    r = '{lat: 0, alu: NONE, pcw: 0, regw: 0, res: 0,
          memreq: 0, memw: 0, imm: 0, irw: 0, halt: 0};
    return r;
  endfunction

  function automatic logic [6:0] opc(input int k);
    case (k)
      K_LOAD:  return 7'b0000011;
      K_STORE: return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BR:    return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  // ALU operation named by the instruction's funct fields.
  function automatic int op_alu(input logic [2:0] f3, input bit is_sub);
    case (f3)
      3'd0: return is_sub ? 2 : 0;  // sub : add
      3'd1: return 1;               // sll
      3'd4: return 4;               // xor
      3'd5: return 5;               // srl
      3'd6: return 6;               // or
      3'd7: return 7;               // and
      default: return 0;
    endcase
  endfunction

  function automatic rec_t model(input int k, input logic [2:0] f3, input logic f7,
                                 input logic z, input logic s, input int fw, input int dw);
    rec_t e;
    bit   tk;
    e = empty_rec();
    e.irw    = 1;
    e.pcw    = 1;               // PC+4 at fetch
    e.memreq = fw + 1;
    case (k)
      K_LOAD: begin
        e.lat = 5 + fw + dw; e.alu = 0; e.regw = 1; e.res = 1;
        e.memreq += dw + 1; e.imm = 0;
      end
      K_STORE: begin
        e.lat = 4 + fw + dw; e.alu = 0; e.memreq += dw + 1; e.memw = dw + 1; e.imm = 1;
      end
      K_R: begin e.lat = 4 + fw; e.alu = op_alu(f3, f7); e.regw = 1; end
      K_I: begin e.lat = 4 + fw; e.alu = op_alu(f3, 1'b0); e.regw = 1; end
      K_BR: begin
        tk = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && s);
        e.lat = 3 + fw; e.alu = 2; e.pcw += int'(tk); e.imm = 2;
      end
      default: begin e.lat = 4 + fw; e.pcw = 2; e.regw = 1; e.imm = 3; end
    endcase
    return e;
  endfunction

  // Monitor: accumulate observations, compare against the scoreboard on retire.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      obs.lat++;
      if (alu_src_a == 2'b10) obs.alu = int'(alu_control);
      if (alu_src_a == 2'b01 && alu_src_b == 2'b01) obs.imm = int'(imm_src);
      if (reg_write) begin obs.regw++; obs.res = int'(result_src); end
      obs.pcw    += int'(pc_write);
      obs.memreq += int'(mem_req);
      obs.memw   += int'(mem_write);
      obs.irw    += int'(ir_write);
      obs.halt   += int'(halted);
      if (instr_done) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_done: instr_done with no instruction pending");
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          check("latency",    obs.lat,    e.lat);
          check("exec_alu",   obs.alu,    e.alu);
          check("pc_writes",  obs.pcw,    e.pcw);
          check("reg_writes", obs.regw,   e.regw);
          check("wb_src",     obs.res,    e.res);
          check("mem_reqs",   obs.memreq, e.memreq);
          check("mem_writes", obs.memw,   e.memw);
          check("dec_imm",    obs.imm,    e.imm);
          check("ir_writes",  obs.irw,    e.irw);
          check("halted",     obs.halt,   e.halt);
        end
        obs = empty_rec();
      end
    end
  end

  // Called at posedge+1 with the DUT in the first FETCH cycle of the instruction.
  task automatic run_instr(input int k, input logic [2:0] f3, input logic f7,
                           input logic z, input logic s, input int fw, input int dw);
    int waits[$];
    int wait_left, cyc;
    bit in_req, done;
    opcode = opc(k); funct3 = f3; funct7b5 = f7; zero = z; sign = s;
    exp_q.push_back(model(k, f3, f7, z, s, fw, dw));
    waits.push_back(fw);
    if (k == K_LOAD || k == K_STORE) waits.push_back(dw);
    in_req = 0; wait_left = 0; cyc = 0; done = 0;
    mon_en = 1;
    while (!done && cyc < 64) begin
      if (mem_req) begin
        if (!in_req) begin
          in_req = 1;
          wait_left = (waits.size() > 0) ? waits.pop_front() : 0;
        end
        if (wait_left > 0) begin mem_ready = 1'b0; wait_left--; end
        else begin mem_ready = 1'b1; in_req = 0; end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (first_fetch_chk) begin
        check("reset_fetch", int'({mem_req, ir_write, pc_write}), 7);
        first_fetch_chk = 0;
      end
      done = instr_done;
      cyc++;
      @(posedge clk); #1;
    end
    check("instr_retired", int'(done), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs = empty_rec();
    rst_n = 1'b0; opcode = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b1;
    zero = 1'b1; sign = 1'b1; mem_ready = 1'b1;
    repeat (2) begin @(negedge clk); check("outs_in_reset", int'(outs), 0); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); check("outs_in_start", int'(outs), 0);
    @(posedge clk); #1;
    first_fetch_chk = 1;

    // Directed instructions.
    run_instr(K_R,    3'd0, 1'b1, 1'b0, 1'b0, 0, 0);  // sub
    run_instr(K_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 0, 2);  // lw, 2 wait states
    run_instr(K_BR,   3'd0, 1'b0, 1'b1, 1'b0, 0, 0);  // beq taken
    run_instr(K_BR,   3'd1, 1'b0, 1'b1, 1'b0, 0, 0);  // bne not taken
    run_instr(K_BR,   3'd4, 1'b0, 1'b0, 1'b1, 0, 0);  // blt taken
    run_instr(K_BR,   3'd2, 1'b0, 1'b1, 1'b1, 0, 0);  // unsupported funct3
    run_instr(K_JAL,  3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(K_STORE,3'd2, 1'b0, 1'b0, 1'b0, 1, 1);
    run_instr(K_I,    3'd0, 1'b1, 1'b0, 1'b0, 0, 0);  // addi ignores funct7b5

    for (int n = 0; n < 150; n++) begin
      run_instr(int'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)));
    end
    mon_en = 0;

    // Illegal opcode: FETCH, DECODE, then TRAP forever.
    opcode = 7'b1111111; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      check("trap_halted", int'(halted), 1);
      check("trap_outs", int'(outs), 1);
    end
    #2 rst_n = 1'b0;
    #1 check("halted_cleared", int'(halted), 0);
    check("trap_reset_outs", int'(outs), 0);

    // Store stuck in a memory wait, aborted by reset.
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; opcode = 7'b0100011; mem_ready = 1'b1;  // FETCH
    @(posedge clk); #1;                                         // DECODE
    @(posedge clk); #1; mem_ready = 1'b0;                       // MEMADR
    @(posedge clk); #1;                                         // MEMWRITE
    @(negedge clk);
    check("store_wait_req", int'({mem_req, mem_write, adr_src, instr_done}), 14);
    #2 rst_n = 1'b0;
    #1 check("abort_mem_req", int'(mem_req), 0);
    check("abort_outs", int'(outs), 0);

    // Controller must restart cleanly after the abort.
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr(K_BR, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0);
    mon_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multi-cycle RV32I core. It steps one shared ALU, a unified instruction/data memory port and the register file through fetch, decode, execute, memory and writeback. Instructions take 3–5 cycles plus memory wait states. A Moore FSM drives mux selects and write strobes. Branch resolution and ALU-function decode are folded in.

## Interface
Parameters: none. Encodings are fixed in `mc_ctrl_pkg`.

- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `opcode` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7b5` in 1: `instr[30]`.
- `zero` in 1: ALU zero flag.
- `sign` in 1: ALU result MSB, used for blt.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: the request is a store.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load the instruction register and latch OldPC.
- `pc_write` out 1: load PC from the result bus.
- `reg_write` out 1: write register-file rd.
- `alu_src_a` out 2: 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = imm, 10 = constant 4.
- `result_src` out 2: 00 = ALUOut, 01 = read data, 10 = ALU result.
- `imm_src` out 2: 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control` out 3: 000 ADD, 001 SLL, 010 SUB, 100 XOR, 101 SRL, 110 OR, 111 AND.
- `instr_done` out 1: one-cycle pulse on the final cycle of each instruction.
- `halted` out 1: an illegal opcode was trapped. Sticky until reset.

## Operation
States are START, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.

- **Reset:** the FSM enters START. While `rst_n` = 0 every output is 0.
- **START:** all outputs are 0. Next state is FETCH.
- **FETCH:**
  - Drives `mem_req` = 1 and `adr_src` = 0.
  - ALU computes PC + 4: src_a = 00, src_b = 10, ADD, `result_src` = 10.
  - While `mem_ready` = 0 the FSM stays in FETCH with `ir_write` = `pc_write` = 0.
  - When `mem_ready` = 1: `ir_write` = 1, `pc_write` = 1, next state DECODE.
- **DECODE:**
  - ALU computes OldPC + imm (the branch/jal target): src_a = 01, src_b = 01, ADD.
  - `imm_src` is taken from `opcode`.
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; anything else → TRAP.
- **MEMADR:** rs1 + imm (src_a = 10, src_b = 01, ADD). Next state MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD:** `mem_req` = 1, `adr_src` = 1. Waits for `mem_ready`, then goes to MEMWB.
- **MEMWB:** `result_src` = 01, `reg_write` = 1, `instr_done` = 1. Next state FETCH.
- **MEMWRITE:** `mem_req` = 1, `mem_write` = 1, `adr_src` = 1. Waits for `mem_ready`; on that cycle `instr_done` = 1 and the next state is FETCH.
- **EXECR / EXECI:**
  - Operands are rs1 and rs2 (EXECR) or rs1 and imm (EXECI).
  - ALU function comes from `funct3`: 000 → ADD, or SUB when R-type and `funct7b5` = 1; 001 SLL; 100 XOR; 101 SRL; 110 OR; 111 AND; others ADD.
  - Next state ALUWB.
- **ALUWB:** `result_src` = 00, `reg_write` = 1, `instr_done` = 1. Next state FETCH.
- **BRANCH:**
  - ALU computes rs1 − rs2 (src_a = 10, src_b = 00, SUB); `result_src` = 00, so the target comes from ALUOut.
  - Taken condition by `funct3`: 000 beq = `zero`; 001 bne = `!zero`; 100 blt = `sign`; any other value is not taken.
  - `pc_write` = taken, `instr_done` = 1. Next state FETCH.
- **JAL:**
  - ALU computes OldPC + 4 (src_a = 01, src_b = 10, ADD).
  - `result_src` = 00 (the target), `pc_write` = 1.
  - Next state ALUWB, which writes OldPC + 4 to rd.
- **TRAP:** `halted` = 1, all strobes 0. The FSM stays in TRAP until reset.

Memory handshake rules:
- `mem_req`, `mem_write` and `adr_src` are held stable until the cycle in which `mem_ready` = 1.
- The request drops in the following state.

## Timing
- With zero wait states, latency is: branch 3 cycles; R-type, I-type, store and jal 4 cycles; load 5 cycles.
- Each cycle of `mem_ready` = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Outputs are combinational from state. The exceptions are FETCH/MEMWRITE outputs qualified by `mem_ready`, and BRANCH `pc_write`, which depends on `zero`/`sign` in the same cycle.
- The state register updates on the rising edge of `clk`.
- Reset asserted mid-instruction, including during a memory wait, aborts the instruction: state goes to START and all outputs go to 0 immediately. There is no partial writeback.
- `instr_done` pulses exactly once per retired instruction. It never pulses in START or TRAP.

## Structure
- `mc_ctrl_pkg`:
  - state enum (4-bit);
  - opcode constants;
  - `alu_src_a` / `alu_src_b` / `result_src` / `imm_src` encodings;
  - `alu_control` encodings;
  - branch `funct3` constants.
- Sub-module `mc_alu_decode`: combinational; maps (`alu_op`, `opcode[5]`, `funct3`, `funct7b5`) to `alu_control`. `alu_op` is an internal 2-bit code driven per state: 00 ADD, 01 SUB, 10 funct.
- The FSM, branch condition and handshake logic live in `multicycle_controller`.

## Test plan
- **Reset and fetch:** hold `rst_n` = 0, then release; `mem_ready` = 1 → one cycle of START with all outputs 0, then FETCH with `mem_req` = 1; `ir_write` = `pc_write` = 1 in that same cycle.
- **R-type SUB:** opcode 0110011, `funct3` 000, `funct7b5` 1 → state sequence FETCH, DECODE, EXECR, ALUWB; `alu_control` = 010 in EXECR; `reg_write` = 1 and `instr_done` = 1 in cycle 4.
- **Load with wait states:** lw with `mem_ready` low for 2 cycles in MEMREAD → `mem_req` = 1 and `adr_src` = 1 held for 3 cycles; total 7 cycles; `result_src` = 01 in MEMWB.
- **Branches:**
  - beq with `zero` = 1 → `pc_write` = 1 in BRANCH;
  - bne with `zero` = 1 → `pc_write` = 0;
  - blt with `sign` = 1 → `pc_write` = 1;
  - `funct3` = 010 → not taken.
- **JAL:** opcode 1101111 → `imm_src` = 11 in DECODE; `pc_write` = 1 in JAL; `reg_write` = 1 in ALUWB; 4 cycles.
- **Illegal opcode and reset abort:**
  - opcode 1111111 → TRAP, `halted` = 1, no strobes for 10 cycles;
  - assert `rst_n` during a MEMWRITE wait → `mem_req` = 0 immediately, `halted` cleared.
